debug_sequencer: RTL and testbench

- Controls the pipeline from the debug link.
- Receives command bytes from the UART receiver and drives the global pipeline enable: continuous run or single step.
- When the pipeline stops, it snapshots the PC and the 32-entry register file (the decode-stage debug bus) and streams them out byte by byte to the UART transmitter.
- Sits at top level, between the UART RX/TX and the pipeline stages.

---
 rtl/debug_sequencer_if.sv | 27 ++
 rtl/debug_sequencer.sv | 145 ++++++++++++++
 tb/tb_debug_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_sequencer_if.sv
// UART-side link of the debug sequencer: command bytes in, dump bytes out.
// master = UART RX/TX wrapper side, slave = debug_sequencer side.
interface debug_sequencer_if #(
    parameter int NB_BYTE = 8
);
    logic [NB_BYTE-1:0] rx_data;
    logic               rx_valid;
    logic               tx_ready;
    logic [NB_BYTE-1:0] tx_data;
    logic               tx_valid;

    modport master (
        output rx_data,
        output rx_valid,
        output tx_ready,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  tx_ready,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/debug_sequencer.sv
// Debug-link pipeline controller: run/step/dump commands, snapshot of PC and register
// file streamed out LSB first. Optional 'B' break command enabled by DEBUG_SEQ_BREAK_EN.
module debug_sequencer #(
    parameter int NB_DATA = 32,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic                      clk,
    input  logic                      i_rst,
    debug_sequencer_if.slave          link,
    input  logic                      i_halt,
    input  logic [NB_DATA-1:0]        i_pc,
    input  logic [N_REGS*NB_DATA-1:0] i_registers,
    output logic                      o_pipe_enable,
    output logic                      o_busy
);

    localparam int               N_BYTES   = ((N_REGS + 1) * NB_DATA) / NB_BYTE;
    localparam logic [7:0]       LAST_BYTE = 8'(N_BYTES - 1);
    localparam logic [NB_BYTE-1:0] CMD_RUN  = NB_BYTE'('h43);
    localparam logic [NB_BYTE-1:0] CMD_STEP = NB_BYTE'('h53);
    localparam logic [NB_BYTE-1:0] CMD_DUMP = NB_BYTE'('h52);

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        STEP,
        SNAP,
        SEND
    } state_t;

    state_t                      state_reg, state_next;
    logic                        enable_reg, enable_next;
    logic                        tx_valid_reg, tx_valid_next;
    logic [NB_BYTE-1:0]          tx_data_reg, tx_data_next;
    logic [7:0]                  byte_cnt_reg, byte_cnt_next;
    logic [NB_DATA-1:0]          shadow_pc_reg;
    logic [N_REGS*NB_DATA-1:0]   shadow_regs_reg;

    // Byte 0 is the PC LSB; register bytes follow in r0..r31 order, each LSB first.
    logic [N_BYTES-1:0][NB_BYTE-1:0] dump_bytes;
    assign dump_bytes = {shadow_regs_reg, shadow_pc_reg};

    logic brk_cmd;
`ifdef DEBUG_SEQ_BREAK_EN
    localparam logic [NB_BYTE-1:0] CMD_BRK = NB_BYTE'('h42);
    assign brk_cmd = link.rx_valid && (link.rx_data == CMD_BRK);
`else
    assign brk_cmd = 1'b0;
`endif

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg       <= IDLE;
            enable_reg      <= 1'b0;
            tx_valid_reg    <= 1'b0;
            tx_data_reg     <= '0;
            byte_cnt_reg    <= '0;
            shadow_pc_reg   <= '0;
            shadow_regs_reg <= '0;
        end else begin
            state_reg    <= state_next;
            enable_reg   <= enable_next;
            tx_valid_reg <= tx_valid_next;
            tx_data_reg  <= tx_data_next;
            byte_cnt_reg <= byte_cnt_next;
            if (state_reg == SNAP) begin
                shadow_pc_reg   <= i_pc;
                shadow_regs_reg <= i_registers;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        enable_next   = 1'b0;
        tx_valid_next = tx_valid_reg;
        tx_data_next  = tx_data_reg;
        byte_cnt_next = byte_cnt_reg;

        unique case (state_reg)
            IDLE: begin
                tx_valid_next = 1'b0;
                if (link.rx_valid) begin
                    if (link.rx_data == CMD_RUN) begin
                        state_next = RUN;
                    end else if (link.rx_data == CMD_STEP) begin
                        state_next = STEP;
                    end else if (link.rx_data == CMD_DUMP) begin
                        state_next = SNAP;
                    end
                end
            end

            RUN: begin
                // Halt only counts once an enable cycle has been issued, so a halt
                // already present on entry still lets exactly one cycle through.
                if ((enable_reg && i_halt) || brk_cmd) begin
                    state_next = SNAP;
                end else begin
                    enable_next = 1'b1;
                end
            end

            STEP: begin
                if (enable_reg) begin
                    state_next = SNAP;
                end else begin
                    enable_next = 1'b1;
                end
            end

            SNAP: begin
                // Shadows load on this edge, so byte 0 is taken straight from the live PC.
                byte_cnt_next = '0;
                tx_valid_next = 1'b1;
                tx_data_next  = i_pc[NB_BYTE-1:0];
                state_next    = SEND;
            end

            SEND: begin
                if (tx_valid_reg && link.tx_ready) begin
                    if (byte_cnt_reg == LAST_BYTE) begin
                        tx_valid_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 8'd1;
                        tx_data_next  = dump_bytes[byte_cnt_reg + 8'd1];
                    end
                end
            end

            default: begin
                state_next    = IDLE;
                tx_valid_next = 1'b0;
            end
        endcase
    end

    assign o_pipe_enable = enable_reg;
    assign o_busy        = (state_reg != IDLE);
    assign link.tx_valid = tx_valid_reg;
    assign link.tx_data  = tx_data_reg;

endmodule

// File: tb/tb_debug_sequencer.sv
// Directed self-checking bench for debug_sequencer: step, run/halt, backpressure,
// mid-dump reset, ignored commands and the optional break command.
module tb_debug_sequencer;

    localparam int N_BYTES = 132;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_halt;
    logic [31:0]   i_pc;
    logic [1023:0] i_registers;
    logic          o_pipe_enable;
    logic          o_busy;

    debug_sequencer_if link ();

    debug_sequencer dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .link          (link),
        .i_halt        (i_halt),
        .i_pc          (i_pc),
        .i_registers   (i_registers),
        .o_pipe_enable (o_pipe_enable),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_regs [32];
    logic [7:0]  rx_bytes [N_BYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        if (n < 4) begin
            w = exp_pc;
            return w[8*n +: 8];
        end
        w = exp_regs[(n - 4) / 4];
        return w[8*((n - 4) % 4) +: 8];
    endfunction

    task automatic set_pattern(input logic [31:0] seed);
        for (int i = 0; i < 32; i++) exp_regs[i] = (32'h01030507 * (i + 1)) ^ seed;
    endtask

    task automatic drive_inputs();
        i_pc = exp_pc;
        for (int i = 0; i < 32; i++) i_registers[i*32 +: 32] = exp_regs[i];
    endtask

    task automatic send_cmd(input logic [7:0] b);
        link.rx_data  = b;
        link.rx_valid = 1'b1;
        @(negedge clk);
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
    endtask

    task automatic wait_valid(input string tag);
        int c = 0;
        while (!link.tx_valid && c < 50) begin
            c++;
            @(negedge clk);
        end
        check(tag, link.tx_valid, 1'b1);
    endtask

    // Starts at a negedge where the first byte is (or is about to be) presented.
    task automatic receive_dump(input bit bp, input bit inject, input string tag);
        int         got = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (got < N_BYTES && cyc < 2000) begin
            link.tx_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            if (inject && cyc == 5) begin
                link.rx_data  = 8'h53;
                link.rx_valid = 1'b1;
            end else if (inject && cyc == 6) begin
                link.rx_valid = 1'b0;
                link.rx_data  = 8'h00;
            end
            if (stalled) begin
                check($sformatf("%s_hold_valid_b%0d", tag, got), link.tx_valid, 1'b1);
                check($sformatf("%s_hold_data_b%0d", tag, got), link.tx_data, held);
            end
            if (link.tx_valid && link.tx_ready) begin
                rx_bytes[got] = link.tx_data;
                check($sformatf("%s_byte%0d", tag, got), link.tx_data, exp_byte(got));
                got++;
                stalled = 1'b0;
            end else begin
                stalled = link.tx_valid;
                held    = link.tx_data;
            end
            cyc++;
            @(negedge clk);
        end
        link.rx_valid = 1'b0;
        check({tag, "_count"}, got, N_BYTES);
        check({tag, "_end_valid"}, link.tx_valid, 1'b0);
        check({tag, "_end_busy"}, o_busy, 1'b0);
        check({tag, "_end_enable"}, o_pipe_enable, 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_cnt;
        int c;
        int got;

        i_rst         = 1'b1;
        i_halt        = 1'b0;
        i_pc          = '0;
        i_registers   = '0;
        link.rx_data  = 8'h00;
        link.rx_valid = 1'b0;
        link.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", link.tx_valid, 1'b0);
        check("rst_tx_data", link.tx_data, 8'h00);
        check("rst_enable", o_pipe_enable, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        i_rst = 1'b0;
        @(negedge clk);

        // Unknown command in IDLE
        send_cmd(8'h41);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ign41_busy_%0d", k), o_busy, 1'b0);
            check($sformatf("ign41_enable_%0d", k), o_pipe_enable, 1'b0);
            @(negedge clk);
        end

        // Single step, with a stray 'S' during SEND and pipeline inputs changing mid-dump
        set_pattern(32'h5A5A0000);
        exp_regs[1] = 32'hAABBCCDD;
        exp_pc      = 32'h00000010;
        drive_inputs();
        link.tx_ready = 1'b1;
        send_cmd(8'h53);
        en_cnt = 0;
        c = 0;
        while (!link.tx_valid && c < 20) begin
            if (o_pipe_enable) en_cnt++;
            c++;
            @(negedge clk);
        end
        check("step_enable_cycles", en_cnt, 1);
        check("step_dump_start", link.tx_valid, 1'b1);
        i_pc        = 32'hDEADBEEF;
        i_registers = ~i_registers;
        receive_dump(1'b0, 1'b1, "step");
        check("step_b0", rx_bytes[0], 8'h10);
        check("step_b1", rx_bytes[1], 8'h00);
        check("step_b2", rx_bytes[2], 8'h00);
        check("step_b3", rx_bytes[3], 8'h00);
        check("step_b8", rx_bytes[8], 8'hDD);
        check("step_b9", rx_bytes[9], 8'hCC);
        check("step_b10", rx_bytes[10], 8'hBB);
        check("step_b11", rx_bytes[11], 8'hAA);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post_step_enable_%0d", k), o_pipe_enable, 1'b0);
            check($sformatf("post_step_busy_%0d", k), o_busy, 1'b0);
            @(negedge clk);
        end

        // Run until halt raised in cycle 20 after entry
        set_pattern(32'h00C0FFEE);
        exp_pc = 32'h00000123;
        drive_inputs();
        send_cmd(8'h43);
        check("run_c0_enable", o_pipe_enable, 1'b0);
        check("run_c0_busy", o_busy, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check($sformatf("run_c%0d_enable", k), o_pipe_enable, 1'b1);
            if (k == 20) i_halt = 1'b1;
        end
        @(negedge clk);
        check("run_c21_enable", o_pipe_enable, 1'b0);
        check("run_c21_busy", o_busy, 1'b1);
        wait_valid("run_dump_start");
        receive_dump(1'b0, 1'b0, "run");
        repeat (3) @(negedge clk);
        check("halt_in_idle_busy", o_busy, 1'b0);

        // Halt already high on entry: exactly one enable cycle
        set_pattern(32'h0F0F1234);
        exp_pc = 32'h00000200;
        drive_inputs();
        send_cmd(8'h43);
        check("hentry_c0_enable", o_pipe_enable, 1'b0);
        @(negedge clk);
        check("hentry_c1_enable", o_pipe_enable, 1'b1);
        @(negedge clk);
        check("hentry_c2_enable", o_pipe_enable, 1'b0);
        wait_valid("hentry_dump_start");
        receive_dump(1'b0, 1'b0, "hentry");
        i_halt = 1'b0;

        // Dump with TX backpressure 1-0-0-1
        set_pattern(32'h13579BDF);
        exp_pc = 32'hCAFEF00D;
        drive_inputs();
        link.tx_ready = 1'b1;
        send_cmd(8'h52);
        wait_valid("bp_dump_start");
        receive_dump(1'b1, 1'b0, "bp");

        // Reset while byte 10 is pending
        set_pattern(32'h89ABCDEF);
        exp_pc = 32'h0BADF00D;
        drive_inputs();
        send_cmd(8'h52);
        wait_valid("rstmid_dump_start");
        got = 0;
        c = 0;
        while (c < 200) begin
            if (got == 10) break;
            link.tx_ready = 1'b1;
            if (link.tx_valid) got++;
            c++;
            @(negedge clk);
        end
        link.tx_ready = 1'b0;
        check("rstmid_pending_data", link.tx_data, exp_byte(10));
        @(negedge clk);
        check("rstmid_held_valid", link.tx_valid, 1'b1);
        check("rstmid_held_data", link.tx_data, exp_byte(10));
        #2 i_rst = 1'b1;
        #1;
        check("rstmid_tx_valid", link.tx_valid, 1'b0);
        check("rstmid_enable", o_pipe_enable, 1'b0);
        check("rstmid_busy", o_busy, 1'b0);
        check("rstmid_tx_data", link.tx_data, 8'h00);
        @(negedge clk);
        i_rst = 1'b0;
        link.tx_ready = 1'b1;
        @(negedge clk);
        check("rstmid_idle_busy", o_busy, 1'b0);
        send_cmd(8'h52);
        wait_valid("restart_dump_start");
        receive_dump(1'b0, 1'b0, "restart");

        // Break command while running
        set_pattern(32'h24680ACE);
        exp_pc = 32'h0000BEEF;
        drive_inputs();
        send_cmd(8'h43);
        repeat (3) @(negedge clk);
        check("brk_running_enable", o_pipe_enable, 1'b1);
        send_cmd(8'h42);
`ifdef DEBUG_SEQ_BREAK_EN
        check("brk_enable_off", o_pipe_enable, 1'b0);
        wait_valid("brk_dump_start");
        receive_dump(1'b0, 1'b0, "brk");
`else
        for (int k = 0; k < 4; k++) begin
            check($sformatf("nobrk_enable_%0d", k), o_pipe_enable, 1'b1);
            @(negedge clk);
        end
        i_halt = 1'b1;
        @(negedge clk);
        check("nobrk_halt_enable", o_pipe_enable, 1'b0);
        wait_valid("nobrk_dump_start");
        receive_dump(1'b0, 1'b0, "nobrk");
        i_halt = 1'b0;
`endif
        @(negedge clk);
        check("final_busy", o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
